// File: rtl/imem_fetch.sv
// Instruction-fetch requester for synchronous-read instruction memories.
// Issues one word address per cycle under credit control and queues {pc, inst} for decode.
module imem_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter bit          SWAP_BYTES = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [29:0] imem_addr_o,
    input  logic [31:0] imem_inst_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_pc_o,
    output logic [31:0] out_inst_o
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

    function automatic logic [31:0] swap_word(input logic [31:0] w);
        logic [31:0] r;
        if (SWAP_BYTES) begin
            r = {w[7:0], w[15:8], w[23:16], w[31:24]};
        end else begin
            r = w;
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == PTR_LAST) begin
            r = {PW{1'b0}};
        end else begin
            r = p + PTR_ONE;
        end
        return r;
    endfunction

    logic [31:0]   pc_q, pc_d;
    logic          infl_q, infl_d;
    logic [31:0]   infl_pc_q, infl_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]   fifo_inst_q [FIFO_DEPTH];

    logic          pop_s;
    logic          push_s;
    logic          issue_s;
    logic [31:0]   issue_pc_s;
    logic [CW:0]   credit_s;

    assign out_valid_o = (count_q != {CW{1'b0}});
    assign out_pc_o    = fifo_pc_q[rd_ptr_q];
    assign out_inst_o  = fifo_inst_q[rd_ptr_q];
    assign imem_addr_o = issue_pc_s[31:2];

    // Issue credit, capture decision and next-state for PC, in-flight tag and queue bookkeeping.
    always_comb begin
        pop_s      = out_valid_o & out_ready_i;
        // The same-cycle pop frees a slot, so full-rate streaming works with two entries.
        credit_s   = {1'b0, count_q} + {{CW{1'b0}}, infl_q} - {{CW{1'b0}}, pop_s};
        issue_pc_s = redirect_valid_i ? (redirect_pc_i & 32'hFFFF_FFFC) : pc_q;
        issue_s    = redirect_valid_i | (credit_s < DEPTH_C);
        push_s     = infl_q & ~redirect_valid_i;

        pc_d      = pc_q;
        infl_d    = issue_s;
        infl_pc_d = infl_pc_q;
        if (issue_s) begin
            pc_d      = issue_pc_s + 32'd4;
            infl_pc_d = issue_pc_s;
        end else begin
            pc_d      = pc_q;
            infl_pc_d = infl_pc_q;
        end

        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redirect_valid_i) begin
            count_d  = {CW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            wr_ptr_d = {PW{1'b0}};
        end else begin
            rd_ptr_d = pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
            wr_ptr_d = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers and queue storage; returned word is captured in the cycle after issue.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q      <= RESET_PC;
            infl_q    <= 1'b0;
            infl_pc_q <= 32'h0000_0000;
            count_q   <= {CW{1'b0}};
            rd_ptr_q  <= {PW{1'b0}};
            wr_ptr_q  <= {PW{1'b0}};
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_pc_q[i]   <= 32'h0000_0000;
                fifo_inst_q[i] <= 32'h0000_0000;
            end
        end else begin
            pc_q      <= pc_d;
            infl_q    <= infl_d;
            infl_pc_q <= infl_pc_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            if (push_s) begin
                fifo_pc_q[wr_ptr_q]   <= infl_pc_q;
                fifo_inst_q[wr_ptr_q] <= swap_word(imem_inst_i);
            end
        end
    end
endmodule

// File: tb/tb_imem_fetch.sv
// Directed bench for imem_fetch: ROM model with byte-reversed words, per-feature check tasks.
module tb_imem_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [29:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] head_pc;

    imem_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2), .SWAP_BYTES(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .imem_addr_o(imem_addr), .imem_inst_i(imem_inst),
        .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_pc_o(out_pc), .out_inst_o(out_inst)
    );

    always #5 clk = ~clk;

    // Decoded instruction expected at a byte address; word 0 is the test-1 instruction.
    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        if (pc == 32'h0) return 32'h0070_0393;
        return pc ^ 32'hA5A5_0000;
    endfunction

    logic [31:0] rom_word;
    logic [31:0] mem_q;
    assign rom_word  = inst_of({imem_addr, 2'b00});
    assign imem_inst = mem_q;
    always @(posedge clk) mem_q <= {rom_word[7:0], rom_word[15:8], rom_word[23:16], rom_word[31:24]};

    task automatic test_reset();
        logic [31:0] exp;
        rst = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        total += 4;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        if (out_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", out_pc); end
        if (out_inst !== 32'h0) begin bad++; $display("FAIL reset_inst got=%h exp=0", out_inst); end
        if (imem_addr !== 30'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL first_latency got=%0b exp=0", out_valid); end
        @(negedge clk);
        total += 3;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%0b exp=1", out_valid); end
        if (out_pc !== 32'h0) begin bad++; $display("FAIL first_pc got=%h exp=0", out_pc); end
        if (out_inst !== 32'h0070_0393) begin bad++; $display("FAIL first_inst got=%h exp=00700393", out_inst); end
        exp = 32'd4;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total += 3;
            if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid got=%0b exp=1", out_valid); end
            if (out_pc !== exp) begin bad++; $display("FAIL stream_pc got=%h exp=%h", out_pc, exp); end
            if (out_inst !== inst_of(exp)) begin bad++; $display("FAIL stream_inst got=%h exp=%h", out_inst, inst_of(exp)); end
            head_pc = exp;
            exp += 32'd4;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] p, stop_pc, exp;
        p = head_pc;
        stop_pc = p + 32'd8;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total += 3;
            if (out_valid !== 1'b1 || out_pc !== p) begin bad++; $display("FAIL hold_head got=%0b/%h exp=1/%h", out_valid, out_pc, p); end
            if (out_inst !== inst_of(p)) begin bad++; $display("FAIL hold_inst got=%h exp=%h", out_inst, inst_of(p)); end
            if (imem_addr !== stop_pc[31:2]) begin bad++; $display("FAIL hold_addr got=%h exp=%h", imem_addr, stop_pc[31:2]); end
        end
        out_ready = 1'b1;
        exp = p + 32'd4;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total += 2;
            if (out_valid !== 1'b1 || out_pc !== exp) begin bad++; $display("FAIL release_pc got=%0b/%h exp=1/%h", out_valid, out_pc, exp); end
            if (out_inst !== inst_of(exp)) begin bad++; $display("FAIL release_inst got=%h exp=%h", out_inst, inst_of(exp)); end
            head_pc = exp;
            exp += 32'd4;
        end
    endtask

    task automatic test_redirect();
        logic [31:0] exp;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL redir_queued got=%0b exp=1", out_valid); end
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0046;
        #1;
        total++;
        if (imem_addr !== 30'h11) begin bad++; $display("FAIL redir_addr got=%h exp=11", imem_addr); end
        @(negedge clk);
        redirect_valid = 1'b0; out_ready = 1'b1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_flush got=%0b exp=0", out_valid); end
        exp = 32'h44;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total += 2;
            if (out_valid !== 1'b1 || out_pc !== exp) begin bad++; $display("FAIL redir_pc got=%0b/%h exp=1/%h", out_valid, out_pc, exp); end
            if (out_inst !== inst_of(exp)) begin bad++; $display("FAIL redir_inst got=%h exp=%h", out_inst, inst_of(exp)); end
            exp += 32'd4;
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp;
        out_ready = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        @(negedge clk);
        redirect_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL wrap_flush got=%0b exp=0", out_valid); end
        exp = 32'hFFFF_FFF8;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total += 2;
            if (out_valid !== 1'b1 || out_pc !== exp) begin bad++; $display("FAIL wrap_pc got=%0b/%h exp=1/%h", out_valid, out_pc, exp); end
            if (out_inst !== inst_of(exp)) begin bad++; $display("FAIL wrap_inst got=%h exp=%h", out_inst, inst_of(exp)); end
            exp += 32'd4;
        end
    endtask

    task automatic test_mid_reset();
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre got=%0b exp=1", out_valid); end
        #2 rst = 1'b1;
        #1;
        total += 3;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_async got=%0b exp=0", out_valid); end
        if (out_pc !== 32'h0 || out_inst !== 32'h0) begin bad++; $display("FAIL midrst_clear got=%h/%h exp=0/0", out_pc, out_inst); end
        if (imem_addr !== 30'h0) begin bad++; $display("FAIL midrst_addr got=%h exp=0", imem_addr); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_latency got=%0b exp=0", out_valid); end
        @(negedge clk);
        total += 2;
        if (out_valid !== 1'b1 || out_pc !== 32'h0) begin bad++; $display("FAIL midrst_first got=%0b/%h exp=1/0", out_valid, out_pc); end
        if (out_inst !== 32'h0070_0393) begin bad++; $display("FAIL midrst_inst got=%h exp=00700393", out_inst); end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h4) begin bad++; $display("FAIL midrst_second got=%0b/%h exp=1/4", out_valid, out_pc); end
    endtask

    task automatic test_random();
        logic [31:0] exp;
        logic        exp_idle;
        logic        rdy, rv;
        int          idle, pops;
        idle = 0; pops = 0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; out_ready = 1'b1;
        exp = 32'h200; exp_idle = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_idle) begin
                total++;
                if (out_valid !== 1'b0) begin bad++; $display("FAIL rand_flush cyc=%0d got=%0b exp=0", i, out_valid); end
            end
            if (out_valid === 1'b1) begin
                idle = 0;
                total += 2;
                if (out_pc !== exp) begin bad++; $display("FAIL rand_pc cyc=%0d got=%h exp=%h", i, out_pc, exp); end
                if (out_inst !== inst_of(out_pc)) begin bad++; $display("FAIL rand_inst cyc=%0d got=%h exp=%h", i, out_inst, inst_of(out_pc)); end
            end else begin
                idle++;
                if (idle > 3) begin total++; bad++; $display("FAIL rand_stall cyc=%0d idle=%0d exp<=3", i, idle); idle = 0; end
            end
            rdy = ($urandom_range(0, 3) != 0);
            rv  = (i < 395) && ($urandom_range(0, 15) == 0);
            if (out_valid === 1'b1 && rdy) begin exp += 32'd4; pops++; end
            exp_idle = rv;
            out_ready = rdy;
            redirect_valid = rv;
            if (rv) begin
                redirect_pc = $urandom_range(0, 1023);
                exp = redirect_pc & 32'hFFFF_FFFC;
                idle = 0;
            end
        end
        redirect_valid = 1'b0; out_ready = 1'b1;
        total++;
        if (pops < 100) begin bad++; $display("FAIL rand_pops got=%0d exp>=100", pops); end
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
